// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec -- MIPS-style execute stage ALU with an iterative multiply/divide
// unit and HI/LO registers.
//
// Single-cycle ops (ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/
// MFHI/MFLO and anything undecoded) complete on the start edge, and done
// pulses for the following cycle. MULTU (and DIVU when enabled) run for 32
// iterations, one bit per cycle. Busy is high for that time. HI/LO are
// written on the same edge that raises done.
//
// Build option:
//   ALU_DIV_EN  - when defined, DIVU (funct 011011) is a restoring divider.
//                 When undefined, the divider is left out and DIVU behaves
//                 like any undecoded funct.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst       in   asynchronous active-high reset
//   start     in   issue strobe, samples ALUFunc/a/b/shamt
//   ALUFunc   in   6-bit MIPS funct code
//   a, b      in   32-bit operands (rs, rt)
//   shamt     in   5-bit shift amount for SLL/SRL
//   result    out  registered 32-bit result
//   zero      out  result == 0
//   overflow  out  signed overflow of the last completed ADD/SUB
//   busy      out  multiply/divide in flight
//   done      out  one-cycle completion pulse
//   hi, lo    out  HI/LO register contents
// ---------------------------------------------------------------------------
module alu_exec (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [5:0]  ALUFunc,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [4:0]  shamt,
   output logic [31:0] result,
   output logic        zero,
   output logic        overflow,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [5:0] FnSll   = 6'b000000;
   localparam logic [5:0] FnSrl   = 6'b000010;
   localparam logic [5:0] FnMfhi  = 6'b010000;
   localparam logic [5:0] FnMflo  = 6'b010010;
   localparam logic [5:0] FnMultu = 6'b011001;
   localparam logic [5:0] FnAdd   = 6'b100000;
   localparam logic [5:0] FnAddu  = 6'b100001;
   localparam logic [5:0] FnSub   = 6'b100010;
   localparam logic [5:0] FnSubu  = 6'b100011;
   localparam logic [5:0] FnAnd   = 6'b100100;
   localparam logic [5:0] FnOr    = 6'b100101;
   localparam logic [5:0] FnXor   = 6'b100110;
   localparam logic [5:0] FnNor   = 6'b100111;
   localparam logic [5:0] FnSlt   = 6'b101010;
   localparam logic [5:0] FnSltu  = 6'b101011;
`ifdef ALU_DIV_EN
   localparam logic [5:0] FnDivu  = 6'b011011;
`endif

   typedef enum logic {IDLE, RUN} stateT;

   stateT       state;
   logic [5:0]  iterCount;
   logic [5:0]  nextCount;
   logic [31:0] operandReg;
   logic [31:0] workHi;
   logic [31:0] workLo;
   logic [31:0] stepHi;
   logic [31:0] stepLo;
   logic [32:0] mulSum;

   logic [31:0] sumValue;
   logic [31:0] diffValue;
   logic [31:0] aluValue;
   logic        aluOverflow;
   logic        startMul;
   logic        startDiv;

`ifdef ALU_DIV_EN
   logic        iterIsDiv;
   logic [32:0] divShifted;
   logic [31:0] divDiff;
   logic        divFits;
`endif

   // Decode the funct code for the single-cycle datapath. Signed overflow
   // is the classic sign rule: the operands agree in sign (ADD) or differ
   // (SUB) and the wrapped result's sign differs from a. Funct codes that
   // are not decoded fall through with a zero result and no overflow, and
   // MULTU/DIVU only raise a launch request here.
   always_comb begin
      sumValue    = a + b;
      diffValue   = a - b;
      aluValue    = 32'd0;
      aluOverflow = 1'b0;
      startMul    = 1'b0;
      startDiv    = 1'b0;
      case (ALUFunc)
         FnAdd: begin
            aluValue    = sumValue;
            aluOverflow = (a[31] == b[31]) && (sumValue[31] != a[31]);
         end
         FnAddu:  aluValue = sumValue;
         FnSub: begin
            aluValue    = diffValue;
            aluOverflow = (a[31] != b[31]) && (diffValue[31] != a[31]);
         end
         FnSubu:  aluValue = diffValue;
         FnAnd:   aluValue = a & b;
         FnOr:    aluValue = a | b;
         FnXor:   aluValue = a ^ b;
         FnNor:   aluValue = ~(a | b);
         FnSlt:   aluValue = {31'd0, ($signed(a) < $signed(b))};
         FnSltu:  aluValue = {31'd0, (a < b)};
         FnSll:   aluValue = b << shamt;
         FnSrl:   aluValue = b >> shamt;
         FnMfhi:  aluValue = hi;
         FnMflo:  aluValue = lo;
         FnMultu: startMul = 1'b1;
`ifdef ALU_DIV_EN
         FnDivu:  startDiv = 1'b1;
`endif
         default: aluValue = 32'd0;
      endcase
   end

   // One iteration of the multiply/divide engine. It works on a shared
   // 64-bit register {workHi, workLo}. For multiply, workHi is the running
   // upper partial product and workLo holds the unconsumed multiplier bits.
   // Each step adds the multiplicand when the multiplier LSB is set, then
   // shifts the 65-bit sum right by one. For divide, workHi is the partial
   // remainder and workLo holds the dividend bits shifting out as quotient
   // bits shift in. A divisor of zero always "fits", which naturally gives
   // an all-ones quotient and leaves the dividend as the remainder.
   always_comb begin
      nextCount = iterCount + 6'd1;
      mulSum    = {1'b0, workHi} + (workLo[0] ? {1'b0, operandReg} : 33'd0);
      stepHi    = mulSum[32:1];
      stepLo    = {mulSum[0], workLo[31:1]};
`ifdef ALU_DIV_EN
      divShifted = {workHi, workLo[31]};
      divFits    = (divShifted >= {1'b0, operandReg});
      divDiff    = divShifted[31:0] - operandReg;
      if (iterIsDiv) begin
         if (divFits) begin
            stepHi = divDiff;
            stepLo = {workLo[30:0], 1'b1};
         end else begin
            stepHi = divShifted[31:0];
            stepLo = {workLo[30:0], 1'b0};
         end
      end
`endif
   end

   // Control FSM and all architectural registers. In IDLE a start either
   // retires a single-cycle op immediately or launches the iterative unit.
   // In RUN, start is deliberately not looked at, so issue attempts while
   // busy are dropped. The final iteration writes its result straight into
   // HI/LO on the edge that raises done. That lets an MFHI/MFLO issued
   // during the done cycle see the new values. Multiply/divide never touch
   // result, zero or overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         iterCount  <= 6'd0;
         operandReg <= 32'd0;
         workHi     <= 32'd0;
         workLo     <= 32'd0;
         result     <= 32'd0;
         zero       <= 1'b1;
         overflow   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         hi         <= 32'd0;
         lo         <= 32'd0;
`ifdef ALU_DIV_EN
         iterIsDiv  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (startMul || startDiv) begin
                     state      <= RUN;
                     busy       <= 1'b1;
                     iterCount  <= 6'd0;
                     operandReg <= startDiv ? b : a;
                     workHi     <= 32'd0;
                     workLo     <= startDiv ? a : b;
`ifdef ALU_DIV_EN
                     iterIsDiv  <= startDiv;
`endif
                  end else begin
                     result   <= aluValue;
                     zero     <= (aluValue == 32'd0);
                     overflow <= aluOverflow;
                     done     <= 1'b1;
                  end
               end
            end
            RUN: begin
               workHi    <= stepHi;
               workLo    <= stepLo;
               iterCount <= nextCount;
               if (nextCount == 6'd32) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  hi    <= stepHi;
                  lo    <= stepLo;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec -- self-checking bench for alu_exec.
//
// Directed vectors come from a table. Multi-cycle corner cases are written
// out by hand: busy/done timing, a dropped issue while busy, MFHI on the
// done cycle, reset abort and DIVU. A randomized run is checked against an
// arithmetic reference model. The divider checks follow ALU_DIV_EN the same
// way the design does.
// ---------------------------------------------------------------------------
module tb_alu_exec;

   localparam logic [5:0] FnSll   = 6'b000000;
   localparam logic [5:0] FnSrl   = 6'b000010;
   localparam logic [5:0] FnMfhi  = 6'b010000;
   localparam logic [5:0] FnMflo  = 6'b010010;
   localparam logic [5:0] FnMultu = 6'b011001;
   localparam logic [5:0] FnDivu  = 6'b011011;
   localparam logic [5:0] FnAdd   = 6'b100000;
   localparam logic [5:0] FnAddu  = 6'b100001;
   localparam logic [5:0] FnSub   = 6'b100010;
   localparam logic [5:0] FnSubu  = 6'b100011;
   localparam logic [5:0] FnAnd   = 6'b100100;
   localparam logic [5:0] FnOr    = 6'b100101;
   localparam logic [5:0] FnXor   = 6'b100110;
   localparam logic [5:0] FnNor   = 6'b100111;
   localparam logic [5:0] FnSlt   = 6'b101010;
   localparam logic [5:0] FnSltu  = 6'b101011;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  ALUFunc;
   logic [31:0] a;
   logic [31:0] b;
   logic [4:0]  shamt;
   logic [31:0] result;
   logic        zero;
   logic        overflow;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int vecCount  = 0;
   int missCount = 0;

   logic [31:0] mResult = 32'd0;
   logic        mZero   = 1'b1;
   logic        mOvf    = 1'b0;
   logic [31:0] mHi     = 32'd0;
   logic [31:0] mLo     = 32'd0;

   typedef struct {
      logic [5:0]  func;
      logic [31:0] opA;
      logic [31:0] opB;
      logic [4:0]  sh;
      logic [31:0] expResult;
      logic        expZero;
      logic        expOvf;
   } vecT;

   vecT vecs[14];

   alu_exec dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .ALUFunc  (ALUFunc),
      .a        (a),
      .b        (b),
      .shamt    (shamt),
      .result   (result),
      .zero     (zero),
      .overflow (overflow),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Backstop in case something stalls the whole run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Compare one value and keep the running tallies.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vecCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive one issue: inputs change on the falling edge, start is sampled on
   // the next rising edge, and control returns 1 unit after that edge.
   task automatic applyStimulus(input logic [5:0] f, input logic [31:0] x,
                                input logic [31:0] y, input logic [4:0] s);
      @(negedge clk);
      ALUFunc = f;
      a       = x;
      b       = y;
      shamt   = s;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Reference model: works from the architectural rules with plain wide
   // arithmetic, not from any iterative algorithm.
   task automatic refModel(input logic [5:0] f, input logic [31:0] x,
                           input logic [31:0] y, input logic [4:0] s,
                           output bit iter);
      longint      wide;
      logic [63:0] prod;
      iter = 1'b0;
      case (f)
         FnAdd: begin
            mResult = x + y;
            wide    = longint'($signed(x)) + longint'($signed(y));
            mOvf    = (wide != longint'($signed(mResult)));
         end
         FnSub: begin
            mResult = x - y;
            wide    = longint'($signed(x)) - longint'($signed(y));
            mOvf    = (wide != longint'($signed(mResult)));
         end
         FnAddu:  begin mResult = x + y; mOvf = 1'b0; end
         FnSubu:  begin mResult = x - y; mOvf = 1'b0; end
         FnAnd:   begin mResult = x & y; mOvf = 1'b0; end
         FnOr:    begin mResult = x | y; mOvf = 1'b0; end
         FnXor:   begin mResult = x ^ y; mOvf = 1'b0; end
         FnNor:   begin mResult = ~(x | y); mOvf = 1'b0; end
         FnSlt:   begin mResult = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; mOvf = 1'b0; end
         FnSltu:  begin mResult = (x < y) ? 32'd1 : 32'd0; mOvf = 1'b0; end
         FnSll:   begin mResult = y << s; mOvf = 1'b0; end
         FnSrl:   begin mResult = y >> s; mOvf = 1'b0; end
         FnMfhi:  begin mResult = mHi; mOvf = 1'b0; end
         FnMflo:  begin mResult = mLo; mOvf = 1'b0; end
         FnMultu: begin
            prod = {32'd0, x} * {32'd0, y};
            mHi  = prod[63:32];
            mLo  = prod[31:0];
            iter = 1'b1;
         end
`ifdef ALU_DIV_EN
         FnDivu: begin
            if (y == 32'd0) begin
               mLo = 32'hFFFFFFFF;
               mHi = x;
            end else begin
               mLo = x / y;
               mHi = x % y;
            end
            iter = 1'b1;
         end
`endif
         default: begin mResult = 32'd0; mOvf = 1'b0; end
      endcase
      if (!iter) mZero = (mResult == 32'd0);
   endtask

   // Issue one op, wait out the multiply/divide if needed, and check every
   // output against the model.
   task automatic runOp(input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, input logic [4:0] s, input string tag);
      bit iter;
      int lat;
      bit seen;
      refModel(f, x, y, s, iter);
      applyStimulus(f, x, y, s);
      if (iter) begin
         checkOutput({tag, " busy-on"}, {31'd0, busy}, 32'd1);
         lat  = 1;
         seen = 1'b0;
         while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) seen = 1'b1;
         end
         checkOutput({tag, " latency"}, lat, 32'd33);
      end
      checkOutput({tag, " done"},     {31'd0, done},     32'd1);
      checkOutput({tag, " busy"},     {31'd0, busy},     32'd0);
      checkOutput({tag, " result"},   result,            mResult);
      checkOutput({tag, " zero"},     {31'd0, zero},     {31'd0, mZero});
      checkOutput({tag, " overflow"}, {31'd0, overflow}, {31'd0, mOvf});
      checkOutput({tag, " hi"},       hi,                mHi);
      checkOutput({tag, " lo"},       lo,                mLo);
   endtask

   initial begin
      logic [5:0]  opList[16];
      logic [31:0] edgeVals[5];
      logic [5:0]  rf;
      logic [31:0] rx;
      logic [31:0] ry;
      logic [4:0]  rs;
      bit          iter;
      int          busyCycles;
      int          doneAt;
      bit          gotDone;
      bit          seen;

      vecs[0]  = '{FnAdd,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b1};
      vecs[1]  = '{FnSlt,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000001, 1'b0, 1'b0};
      vecs[2]  = '{FnSltu, 32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0};
      vecs[3]  = '{FnSub,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
      vecs[4]  = '{FnAddu, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 1'b0, 1'b0};
      vecs[5]  = '{FnSubu, 32'h00000005, 32'h00000005, 5'd0,  32'h00000000, 1'b1, 1'b0};
      vecs[6]  = '{FnAnd,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 1'b0, 1'b0};
      vecs[7]  = '{FnOr,   32'hF0F0F0F0, 32'h0F0F0000, 5'd0,  32'hFFFFF0F0, 1'b0, 1'b0};
      vecs[8]  = '{FnXor,  32'hAAAAAAAA, 32'hFFFF0000, 5'd0,  32'h5555AAAA, 1'b0, 1'b0};
      vecs[9]  = '{FnNor,  32'h00000000, 32'h00000000, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[10] = '{FnSll,  32'h12345678, 32'h00000001, 5'd31, 32'h80000000, 1'b0, 1'b0};
      vecs[11] = '{FnSrl,  32'h12345678, 32'h80000000, 5'd31, 32'h00000001, 1'b0, 1'b0};
      vecs[12] = '{6'h3F,  32'h00000001, 32'h00000002, 5'd0,  32'h00000000, 1'b1, 1'b0};
      vecs[13] = '{FnAdd,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h00000000, 1'b1, 1'b0};

      opList = '{FnAdd, FnAddu, FnSub, FnSubu, FnAnd, FnOr, FnXor, FnNor,
                 FnSlt, FnSltu, FnSll, FnSrl, FnMfhi, FnMflo, FnMultu, FnDivu};
      edgeVals = '{32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000};

      rst     = 1'b1;
      start   = 1'b0;
      ALUFunc = 6'd0;
      a       = 32'd0;
      b       = 32'd0;
      shamt   = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset result",   result,            32'd0);
      checkOutput("reset zero",     {31'd0, zero},     32'd1);
      checkOutput("reset overflow", {31'd0, overflow}, 32'd0);
      checkOutput("reset busy",     {31'd0, busy},     32'd0);
      checkOutput("reset done",     {31'd0, done},     32'd0);
      checkOutput("reset hi",       hi,                32'd0);
      checkOutput("reset lo",       lo,                32'd0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] directed table");
      for (int i = 0; i < 14; i++) begin
         refModel(vecs[i].func, vecs[i].opA, vecs[i].opB, vecs[i].sh, iter);
         applyStimulus(vecs[i].func, vecs[i].opA, vecs[i].opB, vecs[i].sh);
         checkOutput($sformatf("vec%0d result", i),   result,            vecs[i].expResult);
         checkOutput($sformatf("vec%0d zero", i),     {31'd0, zero},     {31'd0, vecs[i].expZero});
         checkOutput($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].expOvf});
         checkOutput($sformatf("vec%0d done", i),     {31'd0, done},     32'd1);
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d done-drop", i), {31'd0, done}, 32'd0);
      end

      $display("[TB] MULTU timing with dropped issue");
      runOp(FnAdd, 32'h7FFFFFFF, 32'h00000001, 5'd0, "pre-mul add");
      refModel(FnMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, iter);
      applyStimulus(FnMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
      busyCycles = 0;
      doneAt     = 0;
      gotDone    = 1'b0;
      for (int k = 1; k <= 40 && !gotDone; k++) begin
         if (busy) busyCycles++;
         if (k == 5) begin
            ALUFunc = FnAdd;
            a       = 32'd1;
            b       = 32'd1;
            start   = 1'b1;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            gotDone = 1'b1;
            doneAt  = k + 1;
         end
      end
      checkOutput("mul busy cycles", busyCycles, 32'd32);
      checkOutput("mul done cycle",  doneAt,     32'd33);
      checkOutput("mul busy at done", {31'd0, busy}, 32'd0);
      checkOutput("mul hi",  hi, 32'hFFFFFFFE);
      checkOutput("mul lo",  lo, 32'h00000001);
      checkOutput("mul result kept",   result,            32'h80000000);
      checkOutput("mul overflow kept", {31'd0, overflow}, 32'd1);
      runOp(FnMfhi, 32'd0, 32'd0, 5'd0, "mfhi on done");
      runOp(FnMflo, 32'd0, 32'd0, 5'd0, "mflo after");

`ifdef ALU_DIV_EN
      $display("[TB] DIVU");
      runOp(FnDivu, 32'd100, 32'd7, 5'd0, "divu 100/7");
      checkOutput("divu quotient",  lo, 32'd14);
      checkOutput("divu remainder", hi, 32'd2);
      runOp(FnDivu, 32'd5, 32'd0, 5'd0, "divu by zero");
      checkOutput("divu0 lo", lo, 32'hFFFFFFFF);
      checkOutput("divu0 hi", hi, 32'd5);
`else
      $display("[TB] DIVU disabled");
      runOp(FnMultu, 32'd1234, 32'd5678, 5'd0, "pre-divu mul");
      applyStimulus(FnDivu, 32'd100, 32'd7, 5'd0);
      checkOutput("nodiv done",   {31'd0, done}, 32'd1);
      checkOutput("nodiv result", result,        32'd0);
      checkOutput("nodiv zero",   {31'd0, zero}, 32'd1);
      checkOutput("nodiv hi",     hi,            32'd0);
      checkOutput("nodiv lo",     lo,            32'd7006652);
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (busy) seen = 1'b1;
         @(posedge clk);
         #1;
      end
      checkOutput("nodiv busy seen", {31'd0, seen}, 32'd0);
      refModel(FnDivu, 32'd100, 32'd7, 5'd0, iter);
`endif

      $display("[TB] reset abort during MULTU");
      runOp(FnMultu, 32'h00010001, 32'h00030003, 5'd0, "pre-abort mul");
      applyStimulus(FnMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
      repeat (9) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      checkOutput("abort busy", {31'd0, busy}, 32'd0);
      checkOutput("abort done", {31'd0, done}, 32'd0);
      checkOutput("abort hi",   hi,            32'd0);
      checkOutput("abort lo",   lo,            32'd0);
      @(negedge clk);
      rst     = 1'b0;
      mResult = 32'd0;
      mZero   = 1'b1;
      mOvf    = 1'b0;
      mHi     = 32'd0;
      mLo     = 32'd0;
      seen    = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) seen = 1'b1;
      end
      checkOutput("abort no done", {31'd0, seen}, 32'd0);
      checkOutput("abort hi after", hi, 32'd0);
      checkOutput("abort lo after", lo, 32'd0);
      runOp(FnAdd, 32'd2, 32'd3, 5'd0, "post-abort add");
      checkOutput("post-abort sum", result, 32'd5);

      $display("[TB] randomized run");
      for (int i = 0; i < 40; i++) begin
         rf = opList[$urandom_range(0, 15)];
         if ($urandom_range(0, 7) == 0) rf = 6'($urandom);
         rx = ($urandom_range(0, 2) == 0) ? edgeVals[$urandom_range(0, 4)] : 32'($urandom);
         ry = ($urandom_range(0, 2) == 0) ? edgeVals[$urandom_range(0, 4)] : 32'($urandom);
         if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 15));
         rs = 5'($urandom);
         runOp(rf, rx, ry, rs, $sformatf("rnd%0d f=%02h", i, rf));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
